// File: rtl/interface_spimaster_if.sv
// Host-side handshake and SPI pins of one interface_spimaster instance.
// The master modport is the controller's view; slave is the opposite (host/bench) view.
interface interface_spimaster_if #(
  parameter int unsigned BUFFER_SIZE = 144
) ();
  logic                   start;
  logic [BUFFER_SIZE-1:0] tx_data;
  logic [BUFFER_SIZE-1:0] rx_data;
  logic                   rx_header_ok;
  logic                   busy;
  logic                   done;
  logic                   SPI_SCK;
  logic                   SPI_SSEL;
  logic                   SPI_MOSI;
  logic                   SPI_MISO;

  modport master (
    input  start, tx_data, SPI_MISO,
    output rx_data, rx_header_ok, busy, done, SPI_SCK, SPI_SSEL, SPI_MOSI
  );

  modport slave (
    output start, tx_data, SPI_MISO,
    input  rx_data, rx_header_ok, busy, done, SPI_SCK, SPI_SSEL, SPI_MOSI
  );
endinterface

// File: rtl/interface_spimaster.sv
// SPI mode-0 master: one full-duplex BUFFER_SIZE-bit frame per start, MSB first,
// with a header check on the received frame.
module interface_spimaster #(
  parameter int unsigned BUFFER_SIZE = 144,
  parameter int unsigned CLK_DIV     = 4,
  parameter int unsigned CS_SETUP    = 2,
  parameter int unsigned CS_HOLD     = 2,
  parameter int unsigned CS_GAP      = 4,
  parameter logic [31:0] RX_HEADER   = 32'h64617461
) (
  input logic                   clk,
  input logic                   rst,
  interface_spimaster_if.master bus
);

  localparam int unsigned BitW   = $clog2(BUFFER_SIZE + 1);
  localparam int unsigned PhMaxA = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int unsigned PhMaxB = (CS_HOLD > CS_GAP) ? CS_HOLD : CS_GAP;
  localparam int unsigned PhMax  = (PhMaxA > PhMaxB) ? PhMaxA : PhMaxB;
  localparam int unsigned PhW    = $clog2(PhMax + 1);

  localparam logic [PhW-1:0]  SetupLast = PhW'(CS_SETUP - 1);
  localparam logic [PhW-1:0]  DivLast   = PhW'(CLK_DIV - 1);
  localparam logic [PhW-1:0]  HoldLast  = PhW'(CS_HOLD - 1);
  // IDLE itself provides the final SSEL-high cycle, so GAP is one cycle shorter.
  localparam logic [PhW-1:0]  GapLast   = PhW'((CS_GAP > 1) ? (CS_GAP - 2) : 0);
  localparam logic [BitW-1:0] BitLast   = BitW'(BUFFER_SIZE - 1);

  typedef enum logic [2:0] {StIdle, StSetup, StLow, StHigh, StHold, StGap} state_e;

  state_e                 state_q;
  logic [PhW-1:0]         ph_q;
  logic [BitW-1:0]        bit_q;
  logic [BUFFER_SIZE-1:0] tx_q;
  logic [BUFFER_SIZE-1:0] rx_q;
  logic [BUFFER_SIZE-1:0] rx_data_q;
  logic                   hdr_ok_q;
  logic                   sck_q;
  logic                   ssel_q;
  logic                   busy_q;
  logic                   done_q;
  logic [31:0]            rx_hdr;

  // First wire byte is the header LSB byte.
  assign rx_hdr = {rx_q[BUFFER_SIZE-25 -: 8], rx_q[BUFFER_SIZE-17 -: 8],
                   rx_q[BUFFER_SIZE-9 -: 8],  rx_q[BUFFER_SIZE-1 -: 8]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      ph_q      <= '0;
      bit_q     <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      rx_data_q <= '0;
      hdr_ok_q  <= 1'b0;
      sck_q     <= 1'b0;
      ssel_q    <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            tx_q    <= bus.tx_data;
            ssel_q  <= 1'b0;
            busy_q  <= 1'b1;
            ph_q    <= '0;
            bit_q   <= '0;
            state_q <= StSetup;
          end
        end
        StSetup: begin
          if (ph_q == SetupLast) begin
            ph_q    <= '0;
            state_q <= StLow;
          end else begin
            ph_q <= ph_q + 1'b1;
          end
        end
        StLow: begin
          if (ph_q == DivLast) begin
            ph_q    <= '0;
            sck_q   <= 1'b1;
            rx_q    <= {rx_q[BUFFER_SIZE-2:0], bus.SPI_MISO};
            state_q <= StHigh;
          end else begin
            ph_q <= ph_q + 1'b1;
          end
        end
        StHigh: begin
          if (ph_q == DivLast) begin
            ph_q  <= '0;
            sck_q <= 1'b0;
            bit_q <= bit_q + 1'b1;
            if (bit_q == BitLast) begin
              state_q <= StHold;
            end else begin
              // MOSI is the tx MSB, so it advances only on SCK falling edges.
              tx_q    <= {tx_q[BUFFER_SIZE-2:0], 1'b0};
              state_q <= StLow;
            end
          end else begin
            ph_q <= ph_q + 1'b1;
          end
        end
        StHold: begin
          if (ph_q == HoldLast) begin
            ph_q      <= '0;
            ssel_q    <= 1'b1;
            done_q    <= 1'b1;
            rx_data_q <= rx_q;
            hdr_ok_q  <= (rx_hdr == RX_HEADER);
            if (CS_GAP == 1) begin
              busy_q  <= 1'b0;
              state_q <= StIdle;
            end else begin
              state_q <= StGap;
            end
          end else begin
            ph_q <= ph_q + 1'b1;
          end
        end
        StGap: begin
          if (ph_q == GapLast) begin
            ph_q    <= '0;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else begin
            ph_q <= ph_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.rx_data      = rx_data_q;
  assign bus.rx_header_ok = hdr_ok_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.SPI_SCK      = sck_q;
  assign bus.SPI_SSEL     = ssel_q;
  assign bus.SPI_MOSI     = tx_q[BUFFER_SIZE-1];

endmodule

// File: tb/tb_interface_spimaster.sv
// Bench for interface_spimaster: default 144-bit instance plus a minimal 32-bit instance.
module tb_interface_spimaster;

  localparam int BS = 144;
  localparam int BSB = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  interface_spimaster_if #(.BUFFER_SIZE(BS))  bus_a ();
  interface_spimaster_if #(.BUFFER_SIZE(BSB)) bus_b ();

  interface_spimaster #(
    .BUFFER_SIZE(BS), .CLK_DIV(4), .CS_SETUP(2), .CS_HOLD(2), .CS_GAP(4),
    .RX_HEADER(32'h64617461)
  ) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  interface_spimaster #(
    .BUFFER_SIZE(BSB), .CLK_DIV(1), .CS_SETUP(1), .CS_HOLD(1), .CS_GAP(1),
    .RX_HEADER(32'h64617461)
  ) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  int passed = 0;
  int total  = 0;

  // Slave model for instance A: plays slv_frame MSB first, indexed by SCK rises seen so far.
  logic          loop_a = 1'b1;
  logic [BS-1:0] slv_frame = '0;
  logic          slv_bit;

  // Monitor state, index 0 = instance A, 1 = instance B.
  int cyc = 0;
  int rises[2]       = '{0, 0};
  int last_rise[2]   = '{0, 0};
  int spacing_err[2] = '{0, 0};
  int low_len[2]     = '{0, 0};
  int last_low[2]    = '{0, 0};
  int last_rises[2]  = '{0, 0};
  int done_cnt[2]    = '{0, 0};
  int fall_cnt[2]    = '{0, 0};
  int last_fall[2]   = '{0, 0};
  int prev_fall[2]   = '{0, 0};
  logic [1:0] p_sck  = 2'b00;
  logic [1:0] p_ssel = 2'b11;
  logic [1:0] m_sck, m_ssel, m_done;

  assign m_sck  = {bus_b.SPI_SCK,  bus_a.SPI_SCK};
  assign m_ssel = {bus_b.SPI_SSEL, bus_a.SPI_SSEL};
  assign m_done = {bus_b.done,     bus_a.done};

  always_comb begin
    slv_bit = 1'b0;
    if (rises[0] < BS) slv_bit = slv_frame[BS-1-rises[0]];
    bus_a.SPI_MISO = loop_a ? bus_a.SPI_MOSI : slv_bit;
    bus_b.SPI_MISO = bus_b.SPI_MOSI;
  end

  always @(negedge clk) begin
    cyc <= cyc + 1;
    for (int d = 0; d < 2; d++) begin
      if (m_ssel[d] === 1'b0 && p_ssel[d] === 1'b1) begin
        prev_fall[d] <= last_fall[d];
        last_fall[d] <= cyc;
        fall_cnt[d]  <= fall_cnt[d] + 1;
        rises[d]     <= 0;
        low_len[d]   <= 1;
      end else if (m_ssel[d] === 1'b0) begin
        low_len[d] <= low_len[d] + 1;
      end
      if (m_ssel[d] === 1'b1 && p_ssel[d] === 1'b0) begin
        last_low[d]   <= low_len[d];
        last_rises[d] <= rises[d];
      end
      if (m_sck[d] === 1'b1 && p_sck[d] === 1'b0) begin
        rises[d]     <= rises[d] + 1;
        last_rise[d] <= cyc;
        if (rises[d] > 0 && (cyc - last_rise[d]) != ((d == 0) ? 8 : 2))
          spacing_err[d] <= spacing_err[d] + 1;
      end
      if (m_done[d] === 1'b1) done_cnt[d] <= done_cnt[d] + 1;
    end
    p_sck  <= m_sck;
    p_ssel <= m_ssel;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [BS-1:0] act, input logic [BS-1:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else passed++;
  endtask

  task automatic chk_i(input string nm, input int act, input int exp);
    total++;
    if (act != exp) $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    else passed++;
  endtask

  // Header as seen on the wire: first received byte is the least significant header byte.
  function automatic logic [31:0] hdr_of(input logic [BS-1:0] f);
    logic [31:0] h;
    for (int i = 0; i < 4; i++) h[8*i +: 8] = f[BS-1-8*i -: 8];
    return h;
  endfunction

  task automatic wait_idle_a(input string nm);
    int n = 0;
    while (bus_a.busy && n < 3000) begin
      tick();
      n++;
    end
    chk_i({nm, " idle_timeout"}, (n < 3000) ? 1 : 0, 1);
  endtask

  task automatic frame_a(input string nm, input logic [BS-1:0] tx, input logic loop,
                         input logic [BS-1:0] sf, input logic [BS-1:0] exp_rx,
                         input logic exp_ok);
    int d0 = done_cnt[0];
    int s0 = spacing_err[0];
    bus_a.tx_data = tx;
    loop_a        = loop;
    slv_frame     = sf;
    bus_a.start   = 1'b1;
    tick();
    bus_a.start   = 1'b0;
    chk({nm, " ssel_after_start"}, BS'(bus_a.SPI_SSEL), BS'(1'b0));
    wait_idle_a(nm);
    chk({nm, " rx_data"}, bus_a.rx_data, exp_rx);
    chk({nm, " hdr_ok"}, BS'(bus_a.rx_header_ok), BS'(exp_ok));
    chk_i({nm, " done_pulses"}, done_cnt[0] - d0, 1);
    chk_i({nm, " ssel_low"}, last_low[0], 1156);
    chk_i({nm, " sck_rises"}, last_rises[0], 144);
    chk_i({nm, " sck_spacing"}, spacing_err[0] - s0, 0);
  endtask

  typedef struct {
    string         nm;
    logic [BS-1:0] tx;
    logic [BS-1:0] exp_rx;
    logic          exp_ok;
  } vec_t;

  initial begin
    vec_t vecs[5];
    logic [BS-1:0] tx, sf;
    int n, d0, f0;

    vecs[0] = '{"a5_3c", 144'hA5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A53C,
                         144'hA5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A53C, 1'b0};
    vecs[1] = '{"hdr_good", 144'h617461640123456789ABCDEF0123456789AB,
                            144'h617461640123456789ABCDEF0123456789AB, 1'b1};
    vecs[2] = '{"hdr_bad60", 144'h607461640123456789ABCDEF0123456789AB,
                             144'h607461640123456789ABCDEF0123456789AB, 1'b0};
    vecs[3] = '{"hdr_swapped", 144'h646174610123456789ABCDEF0123456789AB,
                               144'h646174610123456789ABCDEF0123456789AB, 1'b0};
    vecs[4] = '{"zeros", 144'h0, 144'h0, 1'b0};

    bus_a.start = 1'b0;
    bus_a.tx_data = '0;
    bus_b.start = 1'b0;
    bus_b.tx_data = '0;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    chk("rst ssel", BS'(bus_a.SPI_SSEL), BS'(1'b1));
    chk("rst sck", BS'(bus_a.SPI_SCK), BS'(1'b0));
    chk("rst mosi", BS'(bus_a.SPI_MOSI), BS'(1'b0));
    chk("rst busy", BS'(bus_a.busy), BS'(1'b0));
    chk("rst done", BS'(bus_a.done), BS'(1'b0));
    chk("rst rx_data", bus_a.rx_data, '0);
    chk("rst hdr_ok", BS'(bus_a.rx_header_ok), BS'(1'b0));
    chk("rst b ssel", BS'(bus_b.SPI_SSEL), BS'(1'b1));

    // Loopback vectors.
    for (int i = 0; i < 5; i++)
      frame_a(vecs[i].nm, vecs[i].tx, 1'b1, '0, vecs[i].exp_rx, vecs[i].exp_ok);

    // Random tx against a random slave frame; half get a valid header.
    for (int r = 0; r < 4; r++) begin
      tx = {$urandom, $urandom, $urandom, $urandom, $urandom};
      sf = {$urandom, $urandom, $urandom, $urandom, $urandom};
      if (r % 2 == 0) sf[BS-1 -: 32] = 32'h61746164;
      frame_a($sformatf("rand%0d", r), tx, 1'b0, sf, sf, hdr_of(sf) == 32'h64617461);
    end

    // start held high: back-to-back frames at minimum spacing, no overlap.
    tx = {$urandom, $urandom, $urandom, $urandom, $urandom};
    bus_a.tx_data = tx;
    loop_a = 1'b1;
    d0 = done_cnt[0];
    f0 = fall_cnt[0];
    bus_a.start = 1'b1;
    n = 0;
    while (fall_cnt[0] < f0 + 2 && n < 3000) begin
      tick();
      n++;
    end
    bus_a.start = 1'b0;
    chk_i("b2b second_start_seen", (n < 3000) ? 1 : 0, 1);
    chk_i("b2b start_to_start", last_fall[0] - prev_fall[0], 1160);
    chk_i("b2b first_ssel_low", last_low[0], 1156);
    wait_idle_a("b2b");
    chk_i("b2b done_pulses", done_cnt[0] - d0, 2);
    chk_i("b2b second_ssel_low", last_low[0], 1156);
    chk("b2b rx_data", bus_a.rx_data, tx);

    // Reset after the 50th SCK rise aborts the frame silently.
    bus_a.tx_data = {$urandom, $urandom, $urandom, $urandom, $urandom};
    bus_a.start = 1'b1;
    tick();
    bus_a.start = 1'b0;
    n = 0;
    while (rises[0] < 50 && n < 1000) begin
      tick();
      n++;
    end
    chk_i("rstmid reached_50", (n < 1000) ? 1 : 0, 1);
    d0 = done_cnt[0];
    rst = 1'b1;
    tick();
    chk("rstmid ssel", BS'(bus_a.SPI_SSEL), BS'(1'b1));
    chk("rstmid sck", BS'(bus_a.SPI_SCK), BS'(1'b0));
    chk("rstmid mosi", BS'(bus_a.SPI_MOSI), BS'(1'b0));
    chk("rstmid busy", BS'(bus_a.busy), BS'(1'b0));
    chk("rstmid rx_data", bus_a.rx_data, '0);
    rst = 1'b0;
    repeat (1300) tick();
    chk_i("rstmid no_done", done_cnt[0] - d0, 0);
    tx = {$urandom, $urandom, $urandom, $urandom, $urandom};
    frame_a("post_rst", tx, 1'b1, '0, tx, hdr_of(tx) == 32'h64617461);

    // Minimal-timing instance: CLK_DIV=1, all CS timings 1, 32-bit frame.
    d0 = done_cnt[1];
    bus_b.tx_data = 32'h12345678;
    bus_b.start = 1'b1;
    tick();
    bus_b.start = 1'b0;
    n = 0;
    while (bus_b.busy && n < 500) begin
      tick();
      n++;
    end
    chk_i("small idle_timeout", (n < 500) ? 1 : 0, 1);
    chk("small rx_data", BS'(bus_b.rx_data), BS'(32'h12345678));
    chk("small hdr_ok", BS'(bus_b.rx_header_ok), BS'(1'b0));
    chk_i("small ssel_low", last_low[1], 66);
    chk_i("small sck_rises", last_rises[1], 32);
    chk_i("small sck_spacing", spacing_err[1], 0);
    chk_i("small done_pulses", done_cnt[1] - d0, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/interface_spimaster.md
# interface_spimaster

SPI master that drives one full-duplex frame of `BUFFER_SIZE` bits per `start` request. It is the initiator end of the frame link served by `interface_spislave`, and is used for FPGA-to-FPGA expansion links and as the host model in slave-side benches. It shifts out `tx_data` MSB first and captures MISO into `rx_data`. When a frame ends it checks the received 32-bit header word.

## Interface
- `BUFFER_SIZE`, 144: frame length in bits; ≥ 32.
- `CLK_DIV`, 4: SCK half-period in `clk` cycles; ≥ 1.
- `CS_SETUP`, 2: cycles from SSEL falling to the first SCK low phase; ≥ 1.
- `CS_HOLD`, 2: cycles from the last SCK falling edge to SSEL rising; ≥ 1.
- `CS_GAP`, 4: minimum SSEL-high cycles between frames; ≥ 1.
- `RX_HEADER`, 32'h64617461: expected header in the received frame.
- `clk` in 1: single clock; everything is synchronous to its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: frame request; sampled only while `busy`=0.
- `tx_data` in BUFFER_SIZE: frame to send; latched on the accepted `start` cycle.
- `rx_data` out BUFFER_SIZE: last received frame; updated only on `done`.
- `rx_header_ok` out 1: header compare result for the current `rx_data`.
- `busy` out 1: high from the accepted `start` until the gap ends.
- `done` out 1: one-cycle pulse when `rx_data` updates.
- `SPI_SCK` out 1: serial clock; idle low (mode 0).
- `SPI_SSEL` out 1: chip select; active low.
- `SPI_MOSI` out 1: serial data out.
- `SPI_MISO` in 1: serial data in.

## Operation
- States: IDLE, SETUP, LOW, HIGH, HOLD, GAP. All outputs are registered.
- Reset values (any state, including mid-frame): state IDLE.
  - SSEL=1, SCK=0, MOSI=0.
  - busy=0, done=0.
  - rx_data=0, rx_header_ok=0.
  - Shift registers and counters are cleared.
  - An interrupted frame produces no `done`.
- IDLE:
  - On `start`=1, load the tx shift register from `tx_data`.
  - Drive MOSI<=tx_data[BUFFER_SIZE-1], SSEL<=0, busy<=1, then go to SETUP.
  - `start` while busy=1 is ignored; it is not queued.
- SETUP: hold SCK=0 for CS_SETUP cycles, then go to LOW.
- LOW: SCK=0 for CLK_DIV cycles, then go to HIGH.
- HIGH:
  - On entry, SCK<=1 and SPI_MISO is shifted into the rx register LSB (rx <= {rx[BUFFER_SIZE-2:0], MISO}).
  - After CLK_DIV cycles, SCK<=0 and the bit count increments.
  - If the count equals BUFFER_SIZE, go to HOLD. Otherwise MOSI takes the next bit on this same edge and the state goes to LOW.
- HOLD:
  - SCK=0 and SSEL=0 for CS_HOLD cycles.
  - Then SSEL<=1, rx_data<=rx register, rx_header_ok updates, done<=1 for one cycle, and go to GAP.
- GAP: SSEL=1 and busy=1 for CS_GAP cycles. Then busy<=0 and go to IDLE.
- MOSI is held stable from entry to LOW until the following HIGH ends, so it changes only on SCK falling edges.
- Header compare: `rx_header_ok` = ({rx[BS-25:BS-32], rx[BS-17:BS-24], rx[BS-9:BS-16], rx[BS-1:BS-8]} == RX_HEADER).
  - BS is `BUFFER_SIZE`.
  - The first wire byte is the header LSB byte.
  - The result is registered together with rx_data.
- Counters:
  - Bit counter width is $clog2(BUFFER_SIZE+1).
  - Phase counter width is covered by max(CLK_DIV, CS_SETUP, CS_HOLD, CS_GAP).
  - No wrap-around can occur within a frame.

## Timing
- Accepted `start` at edge 0: SSEL=0 and MOSI=bit[BS-1] are visible after edge 0. The first SCK rise is CS_SETUP+CLK_DIV cycles later.
- SCK period: 2·CLK_DIV cycles with 50 % duty.
- Number of rising edges per frame: exactly BUFFER_SIZE.
- SSEL low duration: CS_SETUP + 2·CLK_DIV·BUFFER_SIZE + CS_HOLD cycles (defaults: 1156).
- `done` coincides with the SSEL rising edge.
- `busy` falls CS_GAP cycles after `done`; `start` is accepted on the same cycle `busy` reads 0.
- Start-to-start minimum (defaults): 1156+CS_GAP = 1160 cycles.
- MISO is sampled with no synchronizer. The slave must drive MISO at least one `clk` before SCK rises.

## Test plan
- Loopback MISO=MOSI, tx_data=144'hA5…(repeating A5) with a 0x3C final byte:
  - rx_data equals tx_data.
  - Exactly one `done` pulse.
  - 144 SCK rises, each 8 cycles apart.
  - SSEL low for 1156 cycles.
- Loopback with frame bytes 0x61,0x74,0x61,0x64 first: rx_header_ok=1. With the first byte changed to 0x60: rx_header_ok=0, while rx_data is still updated.
- `start` pulsed every cycle:
  - Frames start only when busy=0; no partial or overlapped frames.
  - Second SSEL fall occurs exactly 1160 cycles after the first.
- `rst` asserted after the 50th SCK rise:
  - Next cycle shows SSEL=1, SCK=0, MOSI=0, busy=0, rx_data=0.
  - No `done` pulse.
  - A following start completes a clean loopback frame.
- CLK_DIV=1, CS_SETUP=CS_HOLD=CS_GAP=1, BUFFER_SIZE=32, loopback 32'h12345678:
  - SCK period is 2 cycles.
  - rx_data=32'h12345678.
  - SSEL low for 66 cycles.
- Against the `interface_spislave` instance driving `tx_data` with header 0x64617461:
  - rx_header_ok=1.
  - The slave's rx_data equals the master's tx_data.
